// File: rtl/arb_mux.sv
// arb_mux: CHANNELS-way valid/ready stream arbiter with a registered output stage.
// Fixed-priority or round-robin selection, with burst locking until in_last.
module arb_mux #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MODE     = 1
) (
  input  logic                          CLK,
  input  logic                          Reset,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  input  logic [CHANNELS-1:0]           in_valid,
  input  logic [CHANNELS-1:0]           in_last,
  output logic [CHANNELS-1:0]           in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_sel,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned SELW = $clog2(CHANNELS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_sel_q, out_sel_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic              load;
  logic              xfer;
  logic              gnt_vld;
  logic [SELW-1:0]   gnt_idx;
  logic              gnt_last;
  int unsigned       rr_idx;
  logic [WIDTH-1:0]  ch_data [CHANNELS];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_split
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign load     = ~out_valid_q | out_ready;
  assign xfer     = load & gnt_vld & ~Reset;
  assign gnt_last = in_last[gnt_idx];
  assign in_ready = {CHANNELS{xfer}} & (CHANNELS'(1) << gnt_idx);

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

  // Eligible winner: the locked channel only, else lowest index or first from rr_ptr
  always_comb begin : grant
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    if (state_q == LOCKED) begin
      gnt_vld = in_valid[lock_ch_q];
      gnt_idx = lock_ch_q;
    end else if (MODE == 0) begin
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
        if (in_valid[SELW'(i)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        rr_idx = (32'(rr_ptr_q) + k) % CHANNELS;
        if (!gnt_vld && in_valid[SELW'(rr_idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(rr_idx);
        end
      end
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (load) begin
      if (xfer) begin
        out_data_d  = ch_data[gnt_idx];
        out_sel_d   = gnt_idx;
        out_last_d  = gnt_last;
        out_valid_d = 1'b1;
        case (state_q)
          IDLE: begin
            if (!gnt_last) begin
              state_d   = LOCKED;
              lock_ch_d = gnt_idx;
            end
          end
          LOCKED: begin
            if (gnt_last) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
        // Pointer advances only at burst boundaries so a burst is never split
        if (MODE != 0 && gnt_last) begin
          rr_ptr_d = (gnt_idx == SELW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin : regs
    if (Reset) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
